load_issue_queue: RTL and testbench
===================================

Name: load_issue_queue

Overview:
- In-order FIFO of address-ready loads between the AGU and the data cache.
- Accepts one load per cycle with its address, physical register (pr) and architectural register (ar).
- Presents the oldest load to the dcache on the lsq_rd_mem / proc2Dcache_addr / lsq_pr / lsq_ar interface and retires it when the dcache port is free (lsq_load_avail).
- Handles pipeline flush and end-of-program drain on rob_halt.

Parameters:
- DEPTH, 8: number of queue entries; power of two, at least 2.
- PTR_W, 3: log2(DEPTH); pointer width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- agu_ld_valid  in  1  AGU presents a load this cycle.
- agu_ld_addr  in  64  load byte address.
- agu_ld_pr  in  7  destination physical register.
- agu_ld_ar  in  5  destination architectural register.
- rob_flush  in  1  squash all queued loads (mispredict).
- rob_halt  in  1  program halt seen; stop accepting, drain.
- lsq_load_avail  in  1  dcache load port free this cycle.
- lq_full  out  1  queue cannot accept; AGU must hold.
- lq_count  out  PTR_W+1  occupied entries.
- lsq_rd_mem  out  1  load request valid to dcache.
- proc2Dcache_addr  out  64  head load address.
- lsq_pr  out  7  head load pr.
- lsq_ar  out  5  head load ar.
- lq_drained  out  1  halt drain complete.

Behaviour:
- Storage: DEPTH entries of {addr, pr, ar}; head and tail pointers of width PTR_W; count of width PTR_W+1. Pointers wrap from DEPTH-1 to 0.
- full = (count == DEPTH); empty = (count == 0). lq_full = full OR state != RUN.
- Issue (combinational, from registered state):
  - lsq_rd_mem = !empty AND lsq_load_avail AND !rob_flush AND state != DONE.
  - proc2Dcache_addr, lsq_pr and lsq_ar always reflect entry[head].
  - Fire = lsq_rd_mem. Head advances at the next rising edge. Zero-cycle latency from lsq_load_avail to request.
- Enqueue: accept = agu_ld_valid AND !lq_full AND !rob_flush. Write entry[tail] and advance tail at the edge.
  - Fullness is judged on the registered count, so a full queue rejects enqueue even when a dequeue fires in the same cycle.
  - Simultaneous accept and fire leaves count unchanged.
- A rejected enqueue is not held internally; the AGU holds its inputs while lq_full = 1.
- Flush: rob_flush = 1 clears head, tail and count to 0 at the edge. No fire and no accept occur that cycle. Entry contents are left as is. State is unchanged, except DRAIN goes to DONE at the next edge through the empty condition.
- State machine:
  - RUN: normal operation. rob_halt = 1 → DRAIN.
  - DRAIN: no accepts; issuing continues. When count == 0, or count == 1 with a fire this cycle, or rob_flush → DONE.
  - DONE: no accepts, no issue; lq_drained = 1. Held until reset.
  - rob_halt is ignored outside RUN. lq_drained = 1 only in DONE.
- Reset (reset = 0, asynchronous):
  - head = tail = count = 0; state = RUN.
  - Outputs: lq_full = 0, lq_count = 0, lsq_rd_mem = 0, lq_drained = 0.
  - Data outputs reflect entry[0]; entries reset to addr = 0, pr = 0, ar = 0.
  - Reset mid-operation discards all entries immediately. Deassertion is taken at the next edge.
- Order is strictly in-order. No address comparison and no store forwarding: store/load ordering is enforced by the dcache through lsq_load_avail = !rob_wr_mem.

Test Plan:
- Reset, then enqueue addrs 0x100, 0x108, 0x110 (pr 7/8/9, ar 1/2/3) with lsq_load_avail = 1 → lsq_rd_mem issues 0x100/pr7, 0x108/pr8, 0x110/pr9 on consecutive cycles starting the cycle after each write; lq_count returns to 0.
- With lsq_load_avail = 0, enqueue 8 loads → lq_full = 1, lq_count = 8; a 9th load (addr 0x200) held while lsq_load_avail = 1 pulses once → not accepted in that cycle, accepted the next, and issue order is preserved.
- Fill to 8, drain 5, enqueue 5 more → tail wraps past entry 7; the issue sequence matches enqueue order exactly.
- Queue holding 4 loads, rob_flush = 1 while agu_ld_valid = 1 and lsq_load_avail = 1 → lsq_rd_mem = 0 that cycle; next cycle lq_count = 0 and the new load is not present.
- 3 loads queued, rob_halt pulse → lq_full = 1 immediately; all 3 loads issue; lq_drained = 1 the cycle after the last fire and stays 1; a later agu_ld_valid is ignored.
- Drive reset = 0 asynchronously mid-cycle with 5 loads queued → lsq_rd_mem and lq_count go to 0 before the next clock edge; after release the queue accepts new loads normally.

Source files
------------

// File: rtl/load_issue_queue.sv
// load_issue_queue
//   In-order FIFO of address-ready loads sitting between the AGU and the
//   data cache. One load may be accepted per cycle. The oldest load is
//   presented to the dcache and retired whenever the dcache load port is
//   free. A flush squashes every queued load. A halt stops acceptance and
//   drains the queue, then parks the queue in DONE until reset.
//
// Ports
//   clock            rising-edge clock
//   reset            asynchronous, active-low reset
//   agu_ld_valid     AGU presents a load this cycle
//   agu_ld_addr      load byte address (64)
//   agu_ld_pr        destination physical register (7)
//   agu_ld_ar        destination architectural register (5)
//   rob_flush        squash all queued loads
//   rob_halt         program halt seen: stop accepting and drain
//   lsq_load_avail   dcache load port free this cycle
//   lq_full          queue cannot accept; the AGU must hold its load
//   lq_count         number of occupied entries (PTR_W+1)
//   lsq_rd_mem       load request valid to the dcache
//   proc2Dcache_addr head load address
//   lsq_pr           head load physical register
//   lsq_ar           head load architectural register
//   lq_drained       halt drain complete
module load_issue_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             agu_ld_valid,
  input  logic [63:0]      agu_ld_addr,
  input  logic [6:0]       agu_ld_pr,
  input  logic [4:0]       agu_ld_ar,
  input  logic             rob_flush,
  input  logic             rob_halt,
  input  logic             lsq_load_avail,
  output logic             lq_full,
  output logic [PTR_W:0]   lq_count,
  output logic             lsq_rd_mem,
  output logic [63:0]      proc2Dcache_addr,
  output logic [6:0]       lsq_pr,
  output logic [4:0]       lsq_ar,
  output logic             lq_drained
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [PTR_W:0] DEPTH_C = DEPTH[PTR_W:0];
  localparam logic [PTR_W:0] ONE_C   = {{PTR_W{1'b0}}, 1'b1};

  state_t             state_reg;
  state_t             state_next;
  logic [PTR_W-1:0]   head_reg;
  logic [PTR_W-1:0]   tail_reg;
  logic [PTR_W:0]     count_reg;
  logic [PTR_W:0]     count_next;

  logic [63:0]        addr_mem [DEPTH];
  logic [6:0]         pr_mem   [DEPTH];
  logic [4:0]         ar_mem   [DEPTH];

  logic               full;
  logic               empty;
  logic               fire;
  logic               accept;

  assign full  = (count_reg == DEPTH_C);
  assign empty = (count_reg == '0);

  // Acceptance is blocked outside RUN so a halted program cannot sneak
  // new loads in behind the drain.
  assign lq_full = full || (state_reg != RUN);

  // Issue is purely combinational from registered state so the request
  // follows lsq_load_avail in the same cycle.
  assign fire   = !empty && lsq_load_avail && !rob_flush && (state_reg != DONE);
  // Fullness uses the registered count: a full queue rejects even when a
  // dequeue fires in the same cycle.
  assign accept = agu_ld_valid && !lq_full && !rob_flush;

  assign lsq_rd_mem       = fire;
  assign proc2Dcache_addr = addr_mem[head_reg];
  assign lsq_pr           = pr_mem[head_reg];
  assign lsq_ar           = ar_mem[head_reg];
  assign lq_count         = count_reg;
  assign lq_drained       = (state_reg == DONE);

  // Entry storage: each entry captures the AGU load when the tail points
  // at it. A flush leaves entry contents untouched; only pointers move.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          addr_mem[gi] <= '0;
          pr_mem[gi]   <= '0;
          ar_mem[gi]   <= '0;
        end else if (accept && (tail_reg == PTR_W'(gi))) begin
          addr_mem[gi] <= agu_ld_addr;
          pr_mem[gi]   <= agu_ld_pr;
          ar_mem[gi]   <= agu_ld_ar;
        end
      end
    end
  endgenerate

  always_comb begin
    count_next = count_reg;
    case ({accept, fire})
      2'b10:   count_next = count_reg + ONE_C;
      2'b01:   count_next = count_reg - ONE_C;
      default: count_next = count_reg;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (rob_flush) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (fire) begin
        head_reg <= head_reg + PTR_W'(1);
      end
      if (accept) begin
        tail_reg <= tail_reg + PTR_W'(1);
      end
      count_reg <= count_next;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN: begin
        if (rob_halt) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        // Finish when nothing is left, when the last entry retires this
        // cycle, or when a flush empties the queue.
        if (empty || ((count_reg == ONE_C) && fire) || rob_flush) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = DONE;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

endmodule

// File: tb/tb_load_issue_queue.sv
// tb_load_issue_queue
//   Directed, self-checking bench for load_issue_queue. Each scenario task
//   drives inputs just after a rising edge and compares the combinational
//   outputs a moment later, well away from the next edge.
module tb_load_issue_queue;

  logic        clock;
  logic        reset;
  logic        agu_ld_valid;
  logic [63:0] agu_ld_addr;
  logic [6:0]  agu_ld_pr;
  logic [4:0]  agu_ld_ar;
  logic        rob_flush;
  logic        rob_halt;
  logic        lsq_load_avail;
  logic        lq_full;
  logic [3:0]  lq_count;
  logic        lsq_rd_mem;
  logic [63:0] proc2Dcache_addr;
  logic [6:0]  lsq_pr;
  logic [4:0]  lsq_ar;
  logic        lq_drained;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_addr;
  logic [6:0]  exp_pr;

  load_issue_queue #(.DEPTH(8), .PTR_W(3)) dut (
    .clock            (clock),
    .reset            (reset),
    .agu_ld_valid     (agu_ld_valid),
    .agu_ld_addr      (agu_ld_addr),
    .agu_ld_pr        (agu_ld_pr),
    .agu_ld_ar        (agu_ld_ar),
    .rob_flush        (rob_flush),
    .rob_halt         (rob_halt),
    .lsq_load_avail   (lsq_load_avail),
    .lq_full          (lq_full),
    .lq_count         (lq_count),
    .lsq_rd_mem       (lsq_rd_mem),
    .proc2Dcache_addr (proc2Dcache_addr),
    .lsq_pr           (lsq_pr),
    .lsq_ar           (lsq_ar),
    .lq_drained       (lq_drained)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] a, input logic [6:0] p,
                       input logic [4:0] r, input logic avail);
    agu_ld_valid   = v;
    agu_ld_addr    = a;
    agu_ld_pr      = p;
    agu_ld_ar      = r;
    lsq_load_avail = avail;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    rob_flush = 1'b0;
    rob_halt  = 1'b0;
    drive(1'b0, 64'h0, 7'd0, 5'd0, 1'b0);
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (lq_full !== 1'b0) begin errors++; $display("FAIL reset_full got=%0b want=0", lq_full); end
    checks++;
    if (lq_count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", lq_count); end
    checks++;
    if (lsq_rd_mem !== 1'b0) begin errors++; $display("FAIL reset_rd_mem got=%0b want=0", lsq_rd_mem); end
    checks++;
    if (lq_drained !== 1'b0) begin errors++; $display("FAIL reset_drained got=%0b want=0", lq_drained); end
    checks++;
    if (proc2Dcache_addr !== 64'h0 || lsq_pr !== 7'd0 || lsq_ar !== 5'd0) begin
      errors++;
      $display("FAIL reset_data got=%h/%0d/%0d want=0/0/0", proc2Dcache_addr, lsq_pr, lsq_ar);
    end
    $display("reset: count=%0d rd_mem=%0b", lq_count, lsq_rd_mem);
  endtask

  task automatic test_basic();
    logic [63:0] a_in  [4];
    logic [6:0]  p_in  [4];
    logic [4:0]  r_in  [4];
    logic        v_in  [4];
    logic        rd_exp[4];
    logic [63:0] a_exp [4];
    logic [6:0]  p_exp [4];
    logic [4:0]  r_exp [4];
    a_in = '{64'h100, 64'h108, 64'h110, 64'h0};
    p_in = '{7'd7, 7'd8, 7'd9, 7'd0};
    r_in = '{5'd1, 5'd2, 5'd3, 5'd0};
    v_in = '{1'b1, 1'b1, 1'b1, 1'b0};
    rd_exp = '{1'b0, 1'b1, 1'b1, 1'b1};
    a_exp = '{64'h0, 64'h100, 64'h108, 64'h110};
    p_exp = '{7'd0, 7'd7, 7'd8, 7'd9};
    r_exp = '{5'd0, 5'd1, 5'd2, 5'd3};
    for (int i = 0; i < 4; i++) begin
      step();
      drive(v_in[i], a_in[i], p_in[i], r_in[i], 1'b1);
      #1;
      checks++;
      if (lsq_rd_mem !== rd_exp[i]) begin
        errors++; $display("FAIL basic_rd_mem[%0d] got=%0b want=%0b", i, lsq_rd_mem, rd_exp[i]);
      end
      if (rd_exp[i]) begin
        checks++;
        if (proc2Dcache_addr !== a_exp[i] || lsq_pr !== p_exp[i] || lsq_ar !== r_exp[i]) begin
          errors++;
          $display("FAIL basic_issue[%0d] got=%h/%0d/%0d want=%h/%0d/%0d", i,
                   proc2Dcache_addr, lsq_pr, lsq_ar, a_exp[i], p_exp[i], r_exp[i]);
        end
        $display("basic: issue addr=%h pr=%0d ar=%0d", proc2Dcache_addr, lsq_pr, lsq_ar);
      end
    end
    step();
    drive(1'b0, 64'h0, 7'd0, 5'd0, 1'b1);
    #1;
    checks++;
    if (lq_count !== 4'd0 || lsq_rd_mem !== 1'b0) begin
      errors++; $display("FAIL basic_empty got count=%0d rd=%0b want 0/0", lq_count, lsq_rd_mem);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < 8; i++) begin
      step();
      drive(1'b1, 64'h1000 + 64'(8 * i), 7'(10 + i), 5'(i), 1'b0);
    end
    // Hold the 9th load; the dcache port frees up for exactly one cycle.
    step();
    drive(1'b1, 64'h200, 7'd30, 5'd20, 1'b1);
    #1;
    checks++;
    if (lq_full !== 1'b1 || lq_count !== 4'd8) begin
      errors++; $display("FAIL full_flag got full=%0b count=%0d want 1/8", lq_full, lq_count);
    end
    checks++;
    if (lsq_rd_mem !== 1'b1 || proc2Dcache_addr !== 64'h1000) begin
      errors++; $display("FAIL full_issue got rd=%0b addr=%h want 1/1000", lsq_rd_mem, proc2Dcache_addr);
    end
    step();
    drive(1'b1, 64'h200, 7'd30, 5'd20, 1'b0);
    #1;
    checks++;
    if (lq_count !== 4'd7 || lq_full !== 1'b0) begin
      errors++; $display("FAIL full_reject got count=%0d full=%0b want 7/0", lq_count, lq_full);
    end
    step();
    drive(1'b0, 64'h0, 7'd0, 5'd0, 1'b1);
    #1;
    checks++;
    if (lq_count !== 4'd8) begin
      errors++; $display("FAIL full_accept_next got count=%0d want 8", lq_count);
    end
    for (int i = 1; i <= 8; i++) begin
      if (i < 8) begin
        exp_addr = 64'h1000 + 64'(8 * i);
        exp_pr   = 7'(10 + i);
      end else begin
        exp_addr = 64'h200;
        exp_pr   = 7'd30;
      end
      checks++;
      if (lsq_rd_mem !== 1'b1 || proc2Dcache_addr !== exp_addr || lsq_pr !== exp_pr) begin
        errors++;
        $display("FAIL full_order[%0d] got rd=%0b addr=%h pr=%0d want 1/%h/%0d", i,
                 lsq_rd_mem, proc2Dcache_addr, lsq_pr, exp_addr, exp_pr);
      end
      $display("full: issue addr=%h pr=%0d", proc2Dcache_addr, lsq_pr);
      step();
      #1;
    end
    checks++;
    if (lq_count !== 4'd0) begin
      errors++; $display("FAIL full_drained got count=%0d want 0", lq_count);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 8; i++) begin
      step();
      drive(1'b1, 64'h3000 + 64'(8 * i), 7'(40 + i), 5'(i), 1'b0);
    end
    step();
    drive(1'b0, 64'h0, 7'd0, 5'd0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      #1;
      exp_addr = 64'h3000 + 64'(8 * i);
      checks++;
      if (lsq_rd_mem !== 1'b1 || proc2Dcache_addr !== exp_addr) begin
        errors++; $display("FAIL wrap_first[%0d] got rd=%0b addr=%h want 1/%h", i,
                           lsq_rd_mem, proc2Dcache_addr, exp_addr);
      end
      step();
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 64'h4000 + 64'(8 * i), 7'(60 + i), 5'(i), 1'b0);
      step();
    end
    drive(1'b0, 64'h0, 7'd0, 5'd0, 1'b1);
    #1;
    checks++;
    if (lq_count !== 4'd8 || lq_full !== 1'b1) begin
      errors++; $display("FAIL wrap_refill got count=%0d full=%0b want 8/1", lq_count, lq_full);
    end
    for (int i = 0; i < 8; i++) begin
      if (i < 3) exp_addr = 64'h3028 + 64'(8 * i);
      else       exp_addr = 64'h4000 + 64'(8 * (i - 3));
      checks++;
      if (lsq_rd_mem !== 1'b1 || proc2Dcache_addr !== exp_addr) begin
        errors++; $display("FAIL wrap_order[%0d] got rd=%0b addr=%h want 1/%h", i,
                           lsq_rd_mem, proc2Dcache_addr, exp_addr);
      end
      $display("wrap: issue addr=%h", proc2Dcache_addr);
      step();
      #1;
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) begin
      step();
      drive(1'b1, 64'h5000 + 64'(8 * i), 7'(70 + i), 5'(i), 1'b0);
    end
    step();
    drive(1'b1, 64'h5800, 7'd99, 5'd9, 1'b1);
    rob_flush = 1'b1;
    #1;
    checks++;
    if (lsq_rd_mem !== 1'b0) begin
      errors++; $display("FAIL flush_no_issue got rd=%0b want 0", lsq_rd_mem);
    end
    step();
    rob_flush = 1'b0;
    drive(1'b0, 64'h0, 7'd0, 5'd0, 1'b1);
    #1;
    checks++;
    if (lq_count !== 4'd0 || lsq_rd_mem !== 1'b0) begin
      errors++; $display("FAIL flush_empty got count=%0d rd=%0b want 0/0", lq_count, lsq_rd_mem);
    end
    // Pointers restart at entry 0 after a flush.
    drive(1'b1, 64'h5100, 7'd11, 5'd4, 1'b1);
    step();
    drive(1'b0, 64'h0, 7'd0, 5'd0, 1'b1);
    #1;
    checks++;
    if (lsq_rd_mem !== 1'b1 || proc2Dcache_addr !== 64'h5100 || lq_count !== 4'd1) begin
      errors++; $display("FAIL flush_refill got rd=%0b addr=%h count=%0d want 1/5100/1",
                         lsq_rd_mem, proc2Dcache_addr, lq_count);
    end
    $display("flush: first post-flush issue addr=%h", proc2Dcache_addr);
    step();
  endtask

  task automatic test_halt();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 64'h6000 + 64'(8 * i), 7'(80 + i), 5'(i), 1'b0);
      step();
    end
    drive(1'b0, 64'h0, 7'd0, 5'd0, 1'b0);
    rob_halt = 1'b1;
    step();
    rob_halt = 1'b0;
    drive(1'b1, 64'h7000, 7'd100, 5'd30, 1'b1);
    #1;
    checks++;
    if (lq_full !== 1'b1) begin
      errors++; $display("FAIL halt_full got=%0b want 1", lq_full);
    end
    for (int i = 0; i < 3; i++) begin
      exp_addr = 64'h6000 + 64'(8 * i);
      checks++;
      if (lsq_rd_mem !== 1'b1 || proc2Dcache_addr !== exp_addr || lq_drained !== 1'b0) begin
        errors++; $display("FAIL halt_issue[%0d] got rd=%0b addr=%h drained=%0b want 1/%h/0", i,
                           lsq_rd_mem, proc2Dcache_addr, lq_drained, exp_addr);
      end
      $display("halt: drain issue addr=%h", proc2Dcache_addr);
      step();
      #1;
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (lq_drained !== 1'b1 || lsq_rd_mem !== 1'b0 || lq_count !== 4'd0) begin
        errors++; $display("FAIL halt_done[%0d] got drained=%0b rd=%0b count=%0d want 1/0/0", i,
                           lq_drained, lsq_rd_mem, lq_count);
      end
      step();
      #1;
    end
    drive(1'b0, 64'h0, 7'd0, 5'd0, 1'b0);
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 64'h7800 + 64'(8 * i), 7'(90 + i), 5'(i), 1'b0);
      step();
    end
    drive(1'b0, 64'h0, 7'd0, 5'd0, 1'b1);
    #1;
    checks++;
    if (lsq_rd_mem !== 1'b1 || lq_count !== 4'd5) begin
      errors++; $display("FAIL areset_pre got rd=%0b count=%0d want 1/5", lsq_rd_mem, lq_count);
    end
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (lsq_rd_mem !== 1'b0 || lq_count !== 4'd0) begin
      errors++; $display("FAIL areset_immediate got rd=%0b count=%0d want 0/0", lsq_rd_mem, lq_count);
    end
    checks++;
    if (proc2Dcache_addr !== 64'h0) begin
      errors++; $display("FAIL areset_data got addr=%h want 0", proc2Dcache_addr);
    end
    step();
    reset = 1'b1;
    drive(1'b1, 64'h8000, 7'd50, 5'd5, 1'b1);
    step();
    drive(1'b0, 64'h0, 7'd0, 5'd0, 1'b1);
    #1;
    checks++;
    if (lsq_rd_mem !== 1'b1 || proc2Dcache_addr !== 64'h8000 || lsq_pr !== 7'd50 || lq_count !== 4'd1) begin
      errors++; $display("FAIL areset_recover got rd=%0b addr=%h pr=%0d count=%0d want 1/8000/50/1",
                         lsq_rd_mem, proc2Dcache_addr, lsq_pr, lq_count);
    end
    $display("areset: post-reset issue addr=%h", proc2Dcache_addr);
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_wrap();
    test_flush();
    test_halt();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
